// File: rtl/usr_pkg.sv
// rtl/usr_pkg.sv - opcode and state definitions for the universal shift register
package usr_pkg;

    localparam logic [2:0] OPC_NOP  = 3'd0;
    localparam logic [2:0] OPC_LOAD = 3'd1;
    localparam logic [2:0] OPC_SHL  = 3'd2;
    localparam logic [2:0] OPC_SHR  = 3'd3;
    localparam logic [2:0] OPC_ROL  = 3'd4;
    localparam logic [2:0] OPC_ROR  = 3'd5;
    localparam logic [2:0] OPC_ASR  = 3'd6;
    localparam logic [2:0] OPC_CLR  = 3'd7;

    typedef enum logic [2:0] {
        OP_NOP  = OPC_NOP,
        OP_LOAD = OPC_LOAD,
        OP_SHL  = OPC_SHL,
        OP_SHR  = OPC_SHR,
        OP_ROL  = OPC_ROL,
        OP_ROR  = OPC_ROR,
        OP_ASR  = OPC_ASR,
        OP_CLR  = OPC_CLR
    } usr_op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } usr_state_e;

    // Opcodes that go through the single-step shifter
    function automatic logic is_shift_op(input logic [2:0] op);
        return (op >= OPC_SHL) && (op <= OPC_ASR);
    endfunction

endpackage

// File: rtl/usr_step.sv
// rtl/usr_step.sv - combinational single-step shift/rotate
// Ports: op (shift opcode), q (current value), sin (serial fill bit),
//        next_q (value after one step), out_bit (bit leaving the register).
module usr_step
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  usr_op_e            op,
    input  logic [WIDTH-1:0]   q,
    input  logic               sin,
    output logic [WIDTH-1:0]   next_q,
    output logic               out_bit
);

    always_comb begin
        next_q  = q;
        out_bit = 1'b0;
        case (op)
            OP_SHL: begin
                next_q  = {q[WIDTH-2:0], sin};
                out_bit = q[WIDTH-1];
            end
            OP_SHR: begin
                next_q  = {sin, q[WIDTH-1:1]};
                out_bit = q[0];
            end
            OP_ROL: begin
                next_q  = {q[WIDTH-2:0], q[WIDTH-1]};
                out_bit = q[WIDTH-1];
            end
            OP_ROR: begin
                next_q  = {q[0], q[WIDTH-1:1]};
                out_bit = q[0];
            end
            OP_ASR: begin
                next_q  = {q[WIDTH-1], q[WIDTH-1:1]};
                out_bit = q[0];
            end
            default: begin
                next_q  = q;
                out_bit = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/usr_reg.sv
// rtl/usr_reg.sv - universal shift register with multi-step shift FSM
// Ports: clk, rst (async active-high), cmd_valid/cmd_ready handshake,
//        cmd_op/cmd_amt command, d (load data), sin (serial fill),
//        q/qb (register and complement), sout (last bit out), done (completion pulse).
module usr_reg
    import usr_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    localparam int              AW      = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2:0]         cmd_op,
    input  logic [AW-1:0]      cmd_amt,
    input  logic [WIDTH-1:0]   d,
    input  logic               sin,
    output logic [WIDTH-1:0]   q,
    output logic [WIDTH-1:0]   qb,
    output logic               sout,
    output logic               done
);

    usr_state_e       state;
    usr_op_e          op_r;
    logic [AW-1:0]    remaining;
    usr_op_e          step_op;
    logic [WIDTH-1:0] step_q;
    logic             step_out;

    // While shifting, the captured opcode drives the stepper; in IDLE the
    // incoming opcode does, so the first step happens on the accept edge.
    assign step_op   = (state == ST_SHIFT) ? op_r : usr_op_e'(cmd_op);
    assign cmd_ready = (state == ST_IDLE);
    assign qb        = ~q;

    usr_step #(.WIDTH(WIDTH)) u_step (
        .op      (step_op),
        .q       (q),
        .sin     (sin),
        .next_q  (step_q),
        .out_bit (step_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            op_r      <= OP_NOP;
            remaining <= '0;
            q         <= RST_VAL;
            sout      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        if (is_shift_op(cmd_op)) begin
                            if (cmd_amt == '0) begin
                                done <= 1'b1;
                            end else begin
                                q    <= step_q;
                                sout <= step_out;
                                if (cmd_amt == AW'(1)) begin
                                    done <= 1'b1;
                                end else begin
                                    state     <= ST_SHIFT;
                                    op_r      <= usr_op_e'(cmd_op);
                                    remaining <= cmd_amt - AW'(1);
                                end
                            end
                        end else begin
                            if (cmd_op == OPC_LOAD) begin
                                q <= d;
                            end else if (cmd_op == OPC_CLR) begin
                                q <= '0;
                            end
                            done <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    q         <= step_q;
                    sout      <= step_out;
                    remaining <= remaining - AW'(1);
                    if (remaining == AW'(1)) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/usr_reg.md
# usr_reg

Parametrised universal shift register: a WIDTH-bit register with complement output, parallel load, clear, and multi-step shift/rotate commands. Commands arrive over a valid/ready handshake. A small FSM executes an N-step shift one bit per clock and flags completion with `done`. It serves as the general-purpose storage/shift element where a plain D flip-flop bank is not enough (serialisers, LFSR seeds, barrel-less shifting).

## Interface
- `WIDTH`, 8: register width, ≥2.
- `RST_VAL`, 0: value of `q` on reset (WIDTH bits).
- Derived: `AW = $clog2(WIDTH)`, the shift-amount width.

- `clk`  in  1  Single clock, rising edge.
- `rst`  in  1  Asynchronous, active-high reset.
- `cmd_valid`  in  1  Command present.
- `cmd_ready`  out  1  Block can accept a command.
- `cmd_op`  in  3  Opcode: 0 NOP, 1 LOAD, 2 SHL, 3 SHR, 4 ROL, 5 ROR, 6 ASR, 7 CLR.
- `cmd_amt`  in  AW  Shift steps, 0..WIDTH-1. Used by ops 2–6 only.
- `d`  in  WIDTH  Parallel load data.
- `sin`  in  1  Serial fill bit for SHL (into LSB) and SHR (into MSB).
- `q`  out  WIDTH  Register contents.
- `qb`  out  WIDTH  Always equals `~q`, combinational.
- `sout`  out  1  Last bit shifted or rotated out (registered).
- `done`  out  1  One-cycle completion pulse (registered).

## Operation
- Accept occurs on a rising edge where `cmd_valid && cmd_ready`. `cmd_op` and `cmd_amt` are captured only at accept.
- **LOAD:** `q <= d`, sampled at accept.
- **CLR:** `q <= 0`. Note this clears to 0, not to RST_VAL.
- **NOP:** `q` unchanged.
- Each of LOAD, CLR, and NOP completes at its accept edge.
- Shift steps (one per edge):
  - SHL: `{q[W-2:0],sin}`, out = MSB.
  - SHR: `{sin,q[W-1:1]}`, out = LSB.
  - ROL: out = MSB.
  - ROR: out = LSB.
  - ASR: MSB replicated, out = LSB.
- `sin` is sampled at every step edge, not only at accept.
- FSM states:
  - IDLE: `cmd_ready=1`. Accept of a shift op with amt ≥ 2 moves to SHIFT, loading remaining = amt−1. Any other accept stays in IDLE.
  - SHIFT: `cmd_ready=0`. Performs one step per edge and decrements remaining. Returns to IDLE on the edge performing the final step.
- `sout` updates only on step edges and holds otherwise.
- `done` is set on the completing edge of any accepted command and cleared on the next edge unless another command completes on that edge.
- Shift with amt=0: no step is performed, `q` and `sout` are unchanged, and `done` still pulses.
- `cmd_valid` arriving while in SHIFT waits; it is not dropped and not accepted.

## Timing
- Reset values: `q=RST_VAL`, `qb=~RST_VAL`, `sout=0`, `done=0`, state IDLE, `cmd_ready=1`. All take effect immediately on `rst` rising, with no clock needed.
- Reset mid-SHIFT aborts the command: no `done` is produced and the remaining steps are discarded.
- Single-cycle ops and shifts with amt ≤ 1: the result is in `q` and `done=1` in the cycle after the accept edge. `cmd_ready` never drops.
- Shift with amt = N ≥ 2:
  - Steps occur on edges E0 (accept) through E(N−1).
  - `cmd_ready` is low from after E0 until after E(N−1).
  - `done` is high in the cycle following E(N−1).
- Back-to-back operation: `cmd_ready` is high in the same cycle `done` is high, so a new command can be accepted on that edge with no bubble.
- `qb` tracks `q` with zero added latency.

## Structure
- Package `usr_pkg` holds:
  - `usr_op_e` (3-bit opcode enum).
  - `usr_state_e` (IDLE, SHIFT).
  - Opcode localparams.
- Sub-module `usr_step`: combinational single-step shifter. Inputs: op, q, sin. Outputs: next_q, out_bit. Instantiated once by `usr_reg`.
- `usr_reg` contains the FSM, the remaining-step counter (AW bits), and the `q`/`sout`/`done` registers.

## Test plan
All scenarios use WIDTH=8 and RST_VAL=0.
- **Async reset:** assert `rst` mid-cycle with `q=3C` → immediately `q=00`, `qb=FF`, `sout=0`, `done=0`, `cmd_ready=1`, with no clock edge.
- **LOAD:** `d=A5` → next cycle `q=A5`, `qb=5A`, `done` high for exactly 1 cycle.
- **SHL amt=3, sin=1, from q=A5:**
  - `q` steps 4B → 97 → 2F.
  - `sout` steps 1 → 0 → 1.
  - `cmd_ready` low 2 cycles; `done` after the third edge.
- **ASR and ROR:**
  - ASR amt=2 from 80 → C0, then E0; `sout` = 0.
  - ROR amt=1 from 81 → C0, `sout` = 1, `cmd_ready` stays high.
- **Reset mid-shift:** ROL amt=7 from 01; assert `rst` after 3 steps (`q=08`) → `q=00`, no `done`. A following LOAD of 5A completes normally.
- **amt=0 and back-to-back:**
  - SHL amt=0 → `q` and `sout` unchanged, `done` pulses.
  - A CLR presented during that `done` cycle is accepted on the same edge → `q=00` and `done` high again on the next cycle.
